// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the programmable clock divider.
package clk_div_pkg;

   localparam int DIV_MIN       = 2;
   localparam int DIV_W_DEFAULT = 8;

   typedef logic [DIV_W_DEFAULT-1:0] div_t;

   function automatic int unsigned half(input int unsigned n);
      return n / 2;
   endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
interface clk_div_prog_if #(parameter int DIV_W = 8);

   logic             en;
   logic [DIV_W-1:0] div_val;
   logic             div_load;
   logic             div_busy;
   logic             div_err;
   logic             po_clk;
   logic             po_pulse;
   logic [DIV_W-1:0] po_cnt;

   modport master (output en, div_val, div_load,
                   input  div_busy, div_err, po_clk, po_pulse, po_cnt);

   modport slave  (input  en, div_val, div_load,
                   output div_busy, div_err, po_clk, po_pulse, po_cnt);

endinterface

// File: rtl/clk_div_duty_fix.sv
// Falling-edge extension of the divided clock so odd divisors get a 50% duty cycle.
module clk_div_duty_fix (
   input  logic clk,
   input  logic rst,
   input  logic rise,
   input  logic odd,
   output logic po_clk
);

   logic fall;

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) fall <= 1'b0;
      else      fall <= rise;
   end

   assign po_clk = odd ? (rise | fall) : rise;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider; new divisors apply at period boundaries.
// Define CLK_DIV_ODD_DUTY50_EN to add the falling-edge stage for 50% duty on odd divisors.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEFAULT,
   parameter int DIV_DEFAULT = 4
) (
   input  logic           clk,
   input  logic           rst,
   clk_div_prog_if.slave  bus
);

   logic [DIV_W-1:0] cnt, n_cur, pend_val;
   logic [DIV_W-1:0] cnt_next, n_next;
   logic             pend, err, clk_rise, pulse;
   logic             last, apply, load_ok, rise_next;

   always_comb begin
      last      = (cnt == n_cur - DIV_W'(1));
      apply     = bus.en && last && pend;
      load_ok   = bus.div_load && (bus.div_val >= DIV_W'(DIV_MIN));
      cnt_next  = last ? '0 : cnt + DIV_W'(1);
      n_next    = apply ? pend_val : n_cur;
      rise_next = (cnt_next < DIV_W'(half(32'(n_next))));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         n_cur    <= DIV_W'(DIV_DEFAULT);
         clk_rise <= 1'b0;
         pulse    <= 1'b0;
      end else if (bus.en) begin
         cnt      <= cnt_next;
         n_cur    <= n_next;
         clk_rise <= rise_next;
         pulse    <= (cnt_next == '0);
      end else begin
         pulse    <= 1'b0;
      end
   end

   // A load landing on a boundary edge survives the clear and waits for the next boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend     <= 1'b0;
         pend_val <= '0;
         err      <= 1'b0;
      end else begin
         err <= bus.div_load && !load_ok;
         if (load_ok) begin
            pend     <= 1'b1;
            pend_val <= bus.div_val;
         end else if (apply) begin
            pend     <= 1'b0;
         end
      end
   end

   assign bus.div_busy = pend;
   assign bus.div_err  = err;
   assign bus.po_pulse = pulse;
   assign bus.po_cnt   = cnt;

`ifdef CLK_DIV_ODD_DUTY50_EN
   clk_div_duty_fix u_duty_fix (
      .clk    (clk),
      .rst    (rst),
      .rise   (clk_rise),
      .odd    (n_cur[0]),
      .po_clk (bus.po_clk)
   );
`else
   assign bus.po_clk = clk_rise;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomised and directed checks of clk_div_prog against a period-level reference model.
module tb_clk_div_prog;

   localparam int DIV_W       = 8;
   localparam int DIV_DEFAULT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #10 clk = ~clk;

   clk_div_prog_if #(.DIV_W(DIV_W)) bus ();

   clk_div_prog #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference state: position inside the current period, active and pending divisor
   int m_cnt, m_n, m_pend, m_pval, m_err, m_pulse, m_started, m_prev_rise;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_rise();
      return (m_started != 0 && m_cnt < m_n / 2) ? 1 : 0;
   endfunction

   function automatic int exp_clk();
`ifdef CLK_DIV_ODD_DUTY50_EN
      return (m_n % 2 == 1) ? (exp_rise() | m_prev_rise) : exp_rise();
`else
      return exp_rise();
`endif
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_n = DIV_DEFAULT; m_pend = 0; m_pval = 0;
      m_err = 0; m_pulse = 0; m_started = 0; m_prev_rise = 0;
   endtask

   task automatic model_step(input int e, input int ld, input int v);
      int rb;
      rb = exp_rise();
      if (e != 0) begin
         m_started = 1;
         if (m_cnt == m_n - 1) begin
            m_cnt = 0;
            if (m_pend != 0) begin
               m_n    = m_pval;
               m_pend = 0;
            end
         end else begin
            m_cnt++;
         end
         m_pulse = (m_cnt == 0) ? 1 : 0;
      end else begin
         m_pulse = 0;
      end
      m_err = (ld != 0 && v < 2) ? 1 : 0;
      if (ld != 0 && v >= 2) begin
         m_pend = 1;
         m_pval = v;
      end
      m_prev_rise = rb;
   endtask

   task automatic check_all();
      chk("po_cnt",   32'(bus.po_cnt),  32'(m_cnt));
      chk("po_clk",   32'(bus.po_clk),  32'(exp_clk()));
      chk("po_pulse", 32'(bus.po_pulse), 32'(m_pulse));
      chk("div_busy", 32'(bus.div_busy), 32'(m_pend));
      chk("div_err",  32'(bus.div_err),  32'(m_err));
   endtask

   task automatic cycle(input logic e, input logic ld, input int v);
      bus.en       = e;
      bus.div_load = ld;
      bus.div_val  = DIV_W'(v);
      @(posedge clk);
      model_step(int'(e), int'(ld), v);
      #1;
      check_all();
   endtask

   task automatic run_until_cnt(input int target, input string tag);
      int found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (m_cnt == target) found = 1;
         else cycle(1'b1, 1'b0, 0);
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_cnt"},   32'(bus.po_cnt),   32'd0);
      chk({tag, "_clk"},   32'(bus.po_clk),   32'd0);
      chk({tag, "_pulse"}, 32'(bus.po_pulse), 32'd0);
      chk({tag, "_busy"},  32'(bus.div_busy), 32'd0);
      chk({tag, "_err"},   32'(bus.div_err),  32'd0);
   endtask

   initial begin
      int hi, found;
      bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
      model_reset();

      #50 check_zero("rst_hold");
      #5 rst = 1'b1;
      #1 check_zero("rst_rel");

      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0);

      // mid-period load of 6, then count high cycles over the first N=6 period
      run_until_cnt(1, "sync_cnt1");
      cycle(1'b1, 1'b1, 6);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         cycle(1'b1, 1'b0, 0);
         if (bus.po_pulse && m_n == 6) found = 1;
      end
      chk("n6_start", 32'(found), 32'd1);
      hi = int'(bus.po_clk);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 0);
         hi += int'(bus.po_clk);
      end
      chk("n6_high", 32'(hi), 32'd3);

      // invalid loads, back to 4, then odd divisor
      cycle(1'b1, 1'b1, 1);
      cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b1, 0);
      cycle(1'b1, 1'b1, 4);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b1, 5);
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 0);

      // enable freeze at cnt=2 with N=4
      cycle(1'b1, 1'b1, 4);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);
      run_until_cnt(2, "sync_cnt2");
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 0);
      cycle(1'b1, 1'b0, 0);
      chk("resume_3", 32'(bus.po_cnt), 32'd3);
      cycle(1'b1, 1'b0, 0);
      chk("resume_0", 32'(bus.po_cnt), 32'd0);

      for (int i = 0; i < 600; i++) begin
         logic e, ld;
         int v;
         e  = ($urandom_range(0, 99) < 85);
         ld = ($urandom_range(0, 99) < 10);
         v  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
         cycle(e, ld, v);
      end

      // async reset with N=6 active and 9 pending
      cycle(1'b1, 1'b1, 6);
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         cycle(1'b1, 1'b0, 0);
         if (m_n == 6 && m_pend == 0) found = 1;
      end
      chk("n6_active", 32'(found), 32'd1);
      cycle(1'b1, 1'b1, 9);
      cycle(1'b1, 1'b0, 0);
      #4 rst = 1'b0;
      #1 check_zero("rst_mid");
      model_reset();
      #3 rst = 1'b1;
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0);
      chk("post_rst_n", 32'(m_n), 32'(DIV_DEFAULT));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider and the parametrised successor of the fixed divide-by-4 block. It divides clk by N, with 2 <= N <= 2^DIV_W-1. It produces a divided clock (po_clk), a one-cycle period strobe (po_pulse) and the live count (po_cnt). A new divisor can be loaded at any time and takes effect only at a period boundary, so the output never has a glitch or a runt period. The block sits in the clock-generation area and feeds timers, LED/blink logic and sampling strobes.

Parameters:
DIV_W, 8, width of the divisor and the counter
DIV_DEFAULT, 4, divisor active after reset; must satisfy 2 <= DIV_DEFAULT <= 2^DIV_W-1

Ports:
clk  in  1  system clock; all logic is rising-edge, except the optional stage described below
rst  in  1  asynchronous, active-low reset
en  in  1  count enable
div_val  in  DIV_W  requested divisor
div_load  in  1  single-cycle strobe that captures div_val
div_busy  out  1  high while a captured divisor is pending
div_err  out  1  single-cycle pulse when div_load carries div_val < 2
po_clk  out  1  divided clock, registered
po_pulse  out  1  high for one clk cycle at the start of each output period
po_cnt  out  DIV_W  current count, range 0..N-1

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, N=DIV_DEFAULT, pend=0, div_busy=0, div_err=0, po_clk=0, po_pulse=0, po_cnt=0.
- Counting, on every rising edge with en=1:
  - cnt_next = (cnt==N-1) ? 0 : cnt+1
  - po_clk <= (cnt_next < N/2), using floor division
  - po_pulse <= (cnt_next==0)
- Resulting waveform with N=4: po_clk pattern 1,1,0,0 repeating. The first output period starts on the first enabled edge after reset release.
- Duty cycle: even N gives exactly 50%. Odd N gives (N-1)/2 cycles high and (N+1)/2 cycles low, unless ODD_DUTY50_EN is defined.
- en=0: cnt and po_clk hold their values, po_pulse=0. Loads are still captured.
- Divisor load:
  - div_load=1 with div_val>=2: pend_val<=div_val, pend<=1, div_busy=1 from the next cycle.
  - div_load=1 with div_val<2: value discarded; div_err=1 for exactly one cycle; existing pend/pend_val unchanged.
  - A second valid load while pending overwrites pend_val (last write wins).
- Boundary application: on an enabled edge with cnt==N-1 and pend=1: N<=pend_val, pend<=0, cnt<=0. po_clk and po_pulse on that edge are computed with the new N.
- A load in the same cycle as a boundary edge is not applied on that edge; it waits for the next boundary.
- Reset mid-operation: everything returns to the reset values, any pending divisor is lost, and N reverts to DIV_DEFAULT.
- Arithmetic: cnt and N are DIV_W bits unsigned. Because cnt wraps at N-1, it never overflows.

Optional Feature:
Macro: CLK_DIV_ODD_DUTY50_EN
- Defined: a falling-edge flop of clk (reset by rst, reset value 0) captures the internal rising-edge po_clk. For odd N, po_clk = rising-edge flop OR falling-edge flop, giving (N/2) cycles high (e.g. 2.5 cycles for N=5). For even N, only the rising-edge flop drives po_clk. po_clk is then no longer purely a flop output.
- Undefined: no falling-edge logic; odd N behaves as described in Behaviour.

Decomposition:
- Package clk_div_pkg:
  - DIV_MIN = 2
  - default DIV_W
  - typedef div_t = logic [DIV_W-1:0]
  - function half(N) returning floor(N/2)
- Sub-module clk_div_duty_fix: the falling-edge stage plus the OR, instantiated only under CLK_DIV_ODD_DUTY50_EN.

Test Plan:
- Reset values: clk period 20 ns, rst=0 for 50 ns -> all outputs 0, po_cnt=0; after release with en=1 -> po_clk period 80 ns, high 40 ns, po_pulse once every 4 cycles.
- Mid-period load: N=4, load div_val=6 at cnt=1 -> div_busy high until the cnt==3 edge; the next period is 120 ns (3 cycles high, 3 low); div_busy=0 afterwards.
- Invalid load: div_val=1 with div_load -> div_err pulses exactly 1 cycle; N stays 4; div_busy stays 0. Repeat with div_val=0 -> same result.
- Odd divisor: load 5 -> macro undefined: 2 cycles high, 3 low (40 ns / 60 ns); macro defined: high 50 ns, low 50 ns.
- Enable freeze: en=0 for 7 cycles at cnt=2 -> po_cnt stays 2, po_clk holds, po_pulse=0; counting resumes 3,0 when en returns to 1.
- Async reset mid-operation: N=6 active with a pending 9, assert rst between edges -> outputs clear immediately; after release, period is 80 ns (N=DIV_DEFAULT) and div_busy=0.
